// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and default word width for serial blocks
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with a one-word holding buffer
// Words queue in the holding register while the shifter drains; a held word follows the last bit with no gap.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  state_e           state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             start;

  // load_ready comes straight from a flop, so accept never races a transfer
  assign accept = load_valid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    word_done_d = 1'b0;
    start       = 1'b0;

    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          start = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (bit_cnt_q == '0) begin
            word_done_d = 1'b1;
            if (hold_full_q) begin
              start = 1'b1;
            end else begin
              state_d     = IDLE;
              ser_out_d   = 1'b0;
              ser_valid_d = 1'b0;
              shift_d     = '0;
            end
          end else begin
            ser_out_d = head_bit(shift_q);
            shift_d   = drop_head(shift_q);
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      hold_full_d = 1'b0;
      shift_d     = drop_head(hold_q);
      ser_out_d   = head_bit(hold_q);
      ser_valid_d = 1'b1;
      bit_cnt_d   = LAST_CNT;
      state_d     = SHIFT;
    end

    busy_d = hold_full_d || (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
      busy_q      <= busy_d;
    end
  end

  assign load_ready = ~hold_full_q;
  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign word_done  = word_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (MSB-first and LSB-first instances)
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0, data_in1 = '0;
  logic       load_valid = 1'b0, load_valid1 = 1'b0;
  logic       shift_en = 1'b1, shift_en1 = 1'b1;
  logic       load_ready, ser_out, ser_valid, word_done, busy;
  logic       load_ready1, ser_out1, ser_valid1, word_done1, busy1;

  int n_pass = 0;
  int n_total = 0;
  int done0 = 0;
  int done1 = 0;
  int det_hits = 0;
  int det_state = 0;
  logic       q0[$];
  logic       q1[$];
  logic [7:0] pending[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .shift_en(shift_en), .ser_out(ser_out),
    .ser_valid(ser_valid), .word_done(word_done), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in1), .load_valid(load_valid1),
    .load_ready(load_ready1), .shift_en(shift_en1), .ser_out(ser_out1),
    .ser_valid(ser_valid1), .word_done(word_done1), .busy(busy1)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_bits0(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q0.push_back(w[i]);
  endtask

  task automatic push_bits1(input logic [7:0] w);
    for (int i = 0; i < 8; i++) q1.push_back(w[i]);
  endtask

  task automatic feed_tick();
    tick();
    if (pending.size() > 0 && load_ready) begin
      data_in    = pending.pop_front();
      load_valid = 1'b1;
      push_bits0(data_in);
    end else begin
      load_valid = 1'b0;
    end
  endtask

  // Scoreboard plus a 1101 non-overlapping Mealy detector fed by consumed bits
  task automatic monitor();
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        det_state = 0;
      end else begin
        if (ser_valid) begin
          n_total++;
          if (q0.size() == 0) $display("FAIL sb0_bit: ser_out=%b but no bit expected", ser_out);
          else if (ser_out !== q0[0]) $display("FAIL sb0_bit: ser_out=%b expected %b", ser_out, q0[0]);
          else n_pass++;
          if (shift_en) begin
            if (q0.size() > 0) void'(q0.pop_front());
            case (det_state)
              0: det_state = ser_out ? 1 : 0;
              1: det_state = ser_out ? 2 : 0;
              2: det_state = ser_out ? 2 : 3;
              default: begin
                if (ser_out) det_hits++;
                det_state = 0;
              end
            endcase
          end
        end
        if (ser_valid1) begin
          n_total++;
          if (q1.size() == 0) $display("FAIL sb1_bit: ser_out1=%b but no bit expected", ser_out1);
          else if (ser_out1 !== q1[0]) $display("FAIL sb1_bit: ser_out1=%b expected %b", ser_out1, q1[0]);
          else n_pass++;
          if (shift_en1 && q1.size() > 0) void'(q1.pop_front());
        end
        if (word_done) done0++;
        if (word_done1) done1++;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_total++;
    if ({ser_out, ser_valid, word_done, busy, load_ready} !== 5'b00001)
      $display("FAIL reset_dut0: out/valid/done/busy/ready=%b expected 00001", {ser_out, ser_valid, word_done, busy, load_ready});
    else n_pass++;
    n_total++;
    if ({ser_out1, ser_valid1, word_done1, busy1, load_ready1} !== 5'b00001)
      $display("FAIL reset_dut1: out/valid/done/busy/ready=%b expected 00001", {ser_out1, ser_valid1, word_done1, busy1, load_ready1});
    else n_pass++;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    int d0 = done0;
    int nv = 0;
    tick();
    data_in = 8'hD0; load_valid = 1'b1; shift_en = 1'b1;
    push_bits0(8'hD0);
    tick();
    load_valid = 1'b0;
    n_total++;
    if ({load_ready, busy, ser_valid} !== 3'b010)
      $display("FAIL s1_after_accept: ready/busy/valid=%b expected 010", {load_ready, busy, ser_valid});
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ser_valid) nv++;
    end
    n_total++;
    if (word_done !== 1'b0) $display("FAIL s1_done_early: word_done=%b expected 0", word_done);
    else n_pass++;
    tick();
    n_total++;
    if ({word_done, ser_valid, ser_out, busy} !== 4'b1000)
      $display("FAIL s1_retire: done/valid/out/busy=%b expected 1000", {word_done, ser_valid, ser_out, busy});
    else n_pass++;
    tick();
    n_total++;
    if (word_done !== 1'b0) $display("FAIL s1_done_pulse: word_done=%b expected 0", word_done);
    else n_pass++;
    tick();
    n_total++;
    if (nv != 8) $display("FAIL s1_valid_cycles: got %0d expected 8", nv);
    else n_pass++;
    n_total++;
    if (done0 - d0 != 1) $display("FAIL s1_done_count: got %0d expected 1", done0 - d0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0 = done0;
    int nv = 0, first = -1, last = -1;
    logic prev_acc = 1'b0;
    shift_en = 1'b1;
    pending.push_back(8'hD0);
    pending.push_back(8'hB4);
    for (int i = 0; i < 30; i++) begin
      feed_tick();
      if (ser_valid) begin
        nv++;
        if (first < 0) first = i;
        last = i;
      end
      if (prev_acc) begin
        n_total++;
        if (load_ready !== 1'b0) $display("FAIL s2_ready_low_when_held: load_ready=%b expected 0", load_ready);
        else n_pass++;
      end
      prev_acc = load_valid;
    end
    n_total++;
    if (nv != 16 || last - first + 1 != 16)
      $display("FAIL s2_contiguous: valid=%0d span=%0d expected 16/16", nv, last - first + 1);
    else n_pass++;
    n_total++;
    if (done0 - d0 != 2) $display("FAIL s2_done_count: got %0d expected 2", done0 - d0);
    else n_pass++;
  endtask

  task automatic test_stall();
    int d0 = done0;
    int nv = 0;
    tick();
    data_in = 8'hD0; load_valid = 1'b1; shift_en = 1'b1;
    push_bits0(8'hD0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      load_valid = 1'b0;
      if (ser_valid) nv++;
      if (i >= 3 && i <= 6) begin
        n_total++;
        if ({ser_valid, ser_out} !== 2'b11) $display("FAIL s3_hold_bit%0d: valid/out=%b expected 11", i, {ser_valid, ser_out});
        else n_pass++;
      end
      shift_en = !(i >= 3 && i <= 5);
    end
    n_total++;
    if (nv != 11) $display("FAIL s3_duration: got %0d cycles expected 11", nv);
    else n_pass++;
    n_total++;
    if (done0 - d0 != 1) $display("FAIL s3_done_count: got %0d expected 1", done0 - d0);
    else n_pass++;
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_seq = 8'b0000_1011;
    tick();
    data_in1 = 8'h0B; load_valid1 = 1'b1; shift_en1 = 1'b1;
    push_bits1(8'h0B);
    tick();
    load_valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if ({ser_valid1, ser_out1} !== {1'b1, exp_seq[i]})
        $display("FAIL s4_lsb_bit%0d: valid/out=%b expected 1%b", i, {ser_valid1, ser_out1}, exp_seq[i]);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({word_done1, ser_valid1} !== 2'b10) $display("FAIL s4_done: done/valid=%b expected 10", {word_done1, ser_valid1});
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_word();
    int d0;
    int nv = 0;
    shift_en = 1'b1;
    pending.push_back(8'hD0);
    pending.push_back(8'hB4);
    for (int i = 0; i < 5; i++) feed_tick();
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_total++;
    if ({ser_out, ser_valid, word_done, busy, load_ready} !== 5'b00001)
      $display("FAIL s5_async_reset: out/valid/done/busy/ready=%b expected 00001", {ser_out, ser_valid, word_done, busy, load_ready});
    else n_pass++;
    q0.delete();
    pending.delete();
    d0 = done0;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ser_valid || busy) nv++;
    end
    n_total++;
    if (nv != 0) $display("FAIL s5_discarded: %0d active cycles after reset expected 0", nv);
    else n_pass++;
    n_total++;
    if (done0 != d0) $display("FAIL s5_no_done: got %0d word_done pulses expected 0", done0 - d0);
    else n_pass++;
  endtask

  task automatic test_detector();
    int h0 = det_hits;
    int d0;
    tick();
    reset = 1'b1;
    tick();
    d0 = done0;
    reset = 1'b0;
    n_total++;
    if (load_ready !== 1'b1) $display("FAIL s6_ready_after_reset: load_ready=%b expected 1", load_ready);
    else n_pass++;
    data_in = 8'hDD; load_valid = 1'b1; shift_en = 1'b1;
    push_bits0(8'hDD);
    pending.push_back(8'h00);
    feed_tick();
    n_total++;
    if ({load_ready, ser_valid} !== 2'b00) $display("FAIL s6_first_edge_accept: ready/valid=%b expected 00", {load_ready, ser_valid});
    else n_pass++;
    feed_tick();
    n_total++;
    if (ser_valid !== 1'b1) $display("FAIL s6_latency: ser_valid=%b expected 1", ser_valid);
    else n_pass++;
    for (int i = 0; i < 22; i++) feed_tick();
    n_total++;
    if (det_hits - h0 != 2) $display("FAIL s6_detector: got %0d hits expected 2", det_hits - h0);
    else n_pass++;
    n_total++;
    if (done0 - d0 != 2) $display("FAIL s6_done_count: got %0d expected 2", done0 - d0);
    else n_pass++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_lsb_first();
    test_reset_mid_word();
    test_detector();
    tick();
    n_total++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL sb_drained: %0d/%0d bits never seen", q0.size(), q1.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning word width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning bit order (1 = MSB first, 0 = LSB first).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high, with ports named clk and reset.
REQ-004 Port clk, input, 1, rising-edge clock for all state.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port data_in, input, WIDTH, parallel word to serialize.
REQ-007 Port load_valid, input, 1, data_in holds a word to accept.
REQ-008 Port load_ready, output, 1, holding buffer can accept a word.
REQ-009 Port shift_en, input, 1, advance one bit this cycle; low stalls the serial output.
REQ-010 Port ser_out, output, 1, serial bit that drives the downstream sequence detector's din.
REQ-011 Port ser_valid, output, 1, ser_out carries a valid bit.
REQ-012 Port word_done, output, 1, single-cycle pulse when the last bit of a word retires.
REQ-013 Port busy, output, 1, high whenever a word is held or being shifted.

Function
REQ-014 A word SHALL be accepted on any rising edge where load_valid and load_ready are both high.
REQ-015 load_ready SHALL equal the inverse of the registered hold_full flag, with no combinational path from any input.
REQ-016 An accepted word SHALL be stored in a one-entry holding register, and hold_full SHALL be set at that edge.
REQ-017 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-018 In IDLE with hold_full=1, the next edge SHALL:
  - transfer the holding register into the shift register;
  - clear hold_full;
  - load bit_cnt=WIDTH-1;
  - enter SHIFT;
  - drive the first bit on ser_out with ser_valid=1.
REQ-019 The latency from the accept edge to the first valid bit SHALL be exactly one clock.
REQ-020 In SHIFT, each edge with shift_en=1 SHALL present the next bit and decrement bit_cnt.
REQ-021 In SHIFT, each edge with shift_en=0 SHALL hold ser_out, ser_valid and bit_cnt unchanged.
REQ-022 Accepts into the holding register SHALL remain permitted while shift_en=0.
REQ-023 The first bit SHALL be data[WIDTH-1] when MSB_FIRST=1 and data[0] when MSB_FIRST=0, continuing in order thereafter.
REQ-024 Last-bit retirement occurs on an edge with bit_cnt=0 and shift_en=1; at that edge word_done SHALL pulse high for exactly one cycle.
REQ-025 At last-bit retirement with hold_full=1, the next word SHALL load on that same edge, with ser_valid staying high, the state staying SHIFT, and no gap bit.
REQ-026 At last-bit retirement with hold_full=0, the block SHALL enter IDLE with ser_valid=0 and ser_out=0.
REQ-027 No accept can coincide with a hold-to-shifter transfer, because load_ready=0 whenever hold_full=1.
REQ-028 bit_cnt SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.
REQ-029 busy SHALL equal hold_full OR (state==SHIFT).
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 Reset SHALL force:
  - state=IDLE;
  - hold_full=0, so load_ready=1;
  - ser_out=0, ser_valid=0, word_done=0, busy=0;
  - bit_cnt=0;
  - shift and holding registers=0.
REQ-032 Reset asserted mid-word SHALL discard both the in-flight word and the held word, and SHALL emit no word_done.
REQ-033 On the first edge after reset deasserts, the block SHALL be able to accept a word.

Structure
REQ-034 The state encoding (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH SHALL live in a shared package, serial_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the holding buffer, shifter, counter and FSM are all inline.

Verification
REQ-036 Scenario 1: WIDTH=8, MSB_FIRST=1, shift_en=1, load 8'hD0 -> ser_out=1,1,0,1,0,0,0,0 on 8 consecutive cycles starting one cycle after accept; word_done on the 8th bit.
REQ-037 Scenario 2: back-to-back loads of 8'hD0 then 8'hB4 -> 16 contiguous ser_valid cycles, two word_done pulses, and load_ready low while hold_full=1.
REQ-038 Scenario 3: shift_en=0 for 3 cycles after the 2nd bit of 8'hD0 -> ser_out held at 1 for 4 cycles, the sequence otherwise unchanged, and total duration 11 cycles.
REQ-039 Scenario 4: MSB_FIRST=0, load 8'h0B -> ser_out=1,1,0,1,0,0,0,0.
REQ-040 Scenario 5: reset asserted after the 3rd bit with a word held -> all outputs 0 immediately, load_ready=1, and no word_done.
REQ-041 Scenario 6: ser_out feeding the 1101 non-overlapping Mealy detector, words 8'hDD then 8'h00 -> detector dout pulses exactly twice.
